serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port cin  input  1  carry-in for add; ignored when sub=1.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-011 SHALL have port sum  output  WIDTH  registered result.
REQ-012 SHALL have port cout  output  1  final carry-out (sub: 1 = no borrow).
REQ-013 SHALL have port overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-014 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-015 IDLE -> RUN on an edge with start=1: load A shift reg with a, B shift reg with b (sub=1: ~b), carry reg with cin (sub=1: 1), bit counter to 0.
REQ-016 RUN: each edge SHALL process one bit LSB-first via a single 1-bit full adder: sum bit shifted into result reg from MSB end, carry reg takes carry-out, operand regs shift right, counter increments.
REQ-017 RUN -> DONE on the edge processing bit WIDTH-1; on that edge sum, cout and overflow (carry into MSB XOR carry out of MSB) SHALL load.
REQ-018 DONE SHALL last exactly one cycle with done=1, then -> IDLE unconditionally.
REQ-019 Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH; back-to-back throughput one operation per WIDTH+2 cycles.
REQ-020 start while busy=1 (RUN or DONE) SHALL be ignored, no effect on operands or state.
REQ-021 sum/cout/overflow SHALL hold their last completed values until the next completion; they SHALL NOT change during RUN.
REQ-022 Counter width SHALL be clog2(WIDTH); no wrap occurs because RUN exits at WIDTH-1.
REQ-023 a, b, sub, cin changing during RUN SHALL not affect the running operation.

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, clear shift regs, carry and counter.
REQ-025 Reset mid-RUN or in DONE SHALL abort the operation with no done pulse; start is ignored while rst_n=0.

Structure
REQ-026 Shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The bit arithmetic SHALL be one instance of the team's existing 1-bit full adder cell (TOP_FullAdder); no other sub-modules.

Verification
REQ-028 WIDTH=8, a=0x5A b=0x33 cin=0 add -> done at cycle 9 after start edge, sum=0x8D cout=0 overflow=1.
REQ-029 a=0xFF b=0x01 cin=0 add -> sum=0x00 cout=1 overflow=0; same with cin=1 -> sum=0x01 cout=1.
REQ-030 sub: a=0x10 b=0x20 -> sum=0xF0 cout=0 overflow=0; a=0x80 b=0x01 -> sum=0x7F cout=1 overflow=1.
REQ-031 start pulsed again at cycles 3 and 9 of a running op with new operands -> ignored, first result unchanged, exactly one done pulse.
REQ-032 rst_n=0 at cycle 4 of RUN -> next cycle busy=0, all outputs 0, no done; subsequent start completes normally.
REQ-033 Back-to-back: start held high continuously -> done pulses every 10 cycles, each result matching the operands sampled at its accept edge.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// Holds the controller state encoding, the default operand width and a sizing helper.
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-index counter width; at least one bit so tiny widths still get a counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 32'd1) ? $clog2(w) : 32'd1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell shared across the team's serial arithmetic blocks.
// Purely combinational; the caller owns the carry register.
module TOP_FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock,
// LSB first, and publishes sum, carry-out and signed overflow at completion.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_cat_s;

  TOP_FullAdder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the top; after the last bit this is the full result.
  assign res_cat_s = {fa_s, res_q};

  // Next-state, datapath and output-register update logic.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          // Subtraction is a + ~b + 1, so cout=1 means no borrow.
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        res_d   = res_cat_s[WIDTH-1:1];
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = res_cat_s;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an arithmetic reference model checked
// every cycle, plus directed operations with hand-computed results.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cycles[$];
  bit chk_en = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: cycle counting plus whole-word arithmetic.
  logic         m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0] m_sum;
  logic [W-1:0] p_sum;
  logic         p_cout, p_ovf;
  int           m_k;

  always @(posedge clk) begin
    logic [W-1:0] bb;
    logic [W:0]   full;
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_k <= 0;
    end else if (!m_busy) begin
      if (start) begin
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        p_sum  <= full[W-1:0];
        p_cout <= full[W];
        p_ovf  <= (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        m_busy <= 1'b1;
        m_k    <= 0;
      end
    end else if (m_k == W) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == W) begin
        m_done <= 1'b1;
        m_sum  <= p_sum;
        m_cout <= p_cout;
        m_ovf  <= p_ovf;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("sum", {56'd0, sum}, {56'd0, m_sum});
      chk("cout", {63'd0, cout}, {63'd0, m_cout});
      chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
      if (done === 1'b1) begin
        done_count++;
        done_cycles.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic icin,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    bit seen;
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    tick();
    start = 1'b0; a = ~ia; b = ~ib; sub = ~isub; cin = ~icin;
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      lat = k;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_30", nm);
    end else begin
      chk({nm, "_latency"}, 64'(lat), 64'(W));
      chk({nm, "_sum"}, {56'd0, sum}, {56'd0, es});
      chk({nm, "_cout"}, {63'd0, cout}, {63'd0, ec});
      chk({nm, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
      chk({nm, "_model_sum"}, {56'd0, m_sum}, {56'd0, es});
      chk({nm, "_model_ovf"}, {63'd0, m_ovf}, {63'd0, eo});
    end
    tick();
  endtask

  initial begin
    int dc0;
    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_sum", {56'd0, sum}, 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ff_01_c", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Restarts during RUN (edge 3) and DONE (edge 9) are ignored.
    dc0 = done_count;
    a = 8'h5A; b = 8'h33; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 8'hC3; b = 8'h7E; sub = 1'b1; cin = 1'b1;
    repeat (2) tick();
    start = 1'b1; a = 8'h11; b = 8'h22;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; a = 8'h44; b = 8'h55;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("ignore_done_pulses", 64'(done_count - dc0), 64'd1);
    chk("ignore_sum", {56'd0, sum}, 64'h8D);
    chk("ignore_ovf", {63'd0, overflow}, 64'd1);

    // Reset at the fourth RUN edge aborts with everything cleared.
    dc0 = done_count;
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", {56'd0, sum}, 64'd0);
    chk("abort_cout", {63'd0, cout}, 64'd0);
    chk("abort_ovf", {63'd0, overflow}, 64'd0);
    tick();
    rst_n = 1'b1; start = 1'b0;
    repeat (12) tick();
    chk("abort_no_done", 64'(done_count - dc0), 64'd0);
    run_op("after_reset", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // Start held high: one accept every W+2 cycles, operands sampled at each accept.
    done_cycles.delete();
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      a = 8'(i * 37 + 5); b = 8'(i * 91 + 3); sub = i[0]; cin = i[1];
      tick();
    end
    start = 1'b0;
    repeat (15) tick();
    chk("b2b_pulse_count", 64'(done_cycles.size()), 64'd5);
    for (int i = 1; i < done_cycles.size(); i++)
      chk("b2b_interval", 64'(done_cycles[i] - done_cycles[i-1]), 64'(W + 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
